// File: rtl/imm_ext_pipe_pkg.sv
// imm_ext_pipe_pkg: shared types for the immediate-extension stage.
// The im_ext_t encoding is the same whether or not IMM_EXT_ZIMM_EN is defined.
package imm_ext_pipe_pkg;
  typedef logic [63:0] u64;
  typedef logic [19:0] u20;
  localparam int IMM_RAW_W = 20;
  localparam int IMM_TAG_MAX = 8;
  typedef enum logic [3:0] {
    EXT_NULL  = 4'd0,
    EXT_ADDI  = 4'd1,
    EXT_SD    = 4'd2,
    EXT_LUI   = 4'd3,
    EXT_JAL   = 4'd4,
    EXT_BEQ   = 4'd5,
    EXT_SHAMT = 4'd6,
    EXT_ZIMM  = 4'd7
  } im_ext_t;
  typedef enum logic [1:0] {CNT_EMPTY = 2'd0, CNT_ONE = 2'd1, CNT_FULL = 2'd2} cnt_t;
  typedef struct packed {
    u64                     imm;
    logic [IMM_TAG_MAX-1:0] tag;
    logic                   fmt_err;
  } imm_beat_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension of a raw field per format.
// EXT_ZIMM is decoded only when IMM_EXT_ZIMM_EN is defined.
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RAW_W = IMM_RAW_W
) (
  input  logic [RAW_W-1:0] i_raw,
  input  im_ext_t          i_fmt,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_fmt_err
);
  localparam int S = $clog2(XLEN);
  logic [11:0] w_shamt_hi;
  assign w_shamt_hi = i_raw[11:0] >> S;
  always_comb begin
    o_imm = '0;
    o_fmt_err = 1'b0;
    case (i_fmt)
      EXT_NULL: o_imm = '0;
      EXT_ADDI, EXT_SD: o_imm = XLEN'($signed(i_raw[11:0]));
      EXT_LUI: o_imm = XLEN'($signed({i_raw[19:0], 12'b0}));
      EXT_JAL: o_imm = XLEN'($signed({i_raw[19:0], 1'b0}));
      EXT_BEQ: o_imm = XLEN'($signed({i_raw[11:0], 1'b0}));
      EXT_SHAMT: begin
        o_imm = XLEN'(i_raw[S-1:0]);
        o_fmt_err = |w_shamt_hi;
      end
`ifdef IMM_EXT_ZIMM_EN
      EXT_ZIMM: o_imm = XLEN'(i_raw[4:0]);
`endif
      default: o_fmt_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extension with a 2-entry skid FIFO and flush.
// Optional macro IMM_EXT_ZIMM_EN enables the EXT_ZIMM format in imm_ext_core.
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RAW_W = IMM_RAW_W,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RAW_W-1:0] in_raw,
  input  im_ext_t          in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_fmt_err
);
  logic [XLEN-1:0] w_imm;
  logic w_err, w_push, w_pop;
  cnt_t r_cnt, w_cnt_nxt;
  logic r_in_ready, r_wptr, r_rptr;
  imm_beat_t r_mem [2];
  imm_beat_t w_head;
  imm_ext_core #(.XLEN(XLEN), .RAW_W(RAW_W)) u_core (
    .i_raw(in_raw),
    .i_fmt(in_fmt),
    .o_imm(w_imm),
    .o_fmt_err(w_err)
  );
  assign in_ready = r_in_ready;
  assign out_valid = r_cnt != CNT_EMPTY;
  assign w_push = in_valid & r_in_ready;
  assign w_pop = out_valid & out_ready;
  assign w_head = r_mem[r_rptr];
  assign out_imm = out_valid ? w_head.imm[XLEN-1:0] : '0;
  assign out_tag = out_valid ? w_head.tag[TAG_W-1:0] : '0;
  assign out_fmt_err = out_valid & w_head.fmt_err;
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_cnt_nxt = flush ? CNT_EMPTY
              : (w_push && !w_pop) ? (r_cnt == CNT_EMPTY ? CNT_ONE : CNT_FULL)
              : (!w_push && w_pop) ? (r_cnt == CNT_FULL ? CNT_ONE : CNT_EMPTY)
              : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= CNT_EMPTY;
      r_in_ready <= 1'b0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_in_ready <= w_cnt_nxt != CNT_FULL;
      r_wptr <= flush ? 1'b0 : r_wptr ^ w_push;
      r_rptr <= flush ? 1'b0 : r_rptr ^ w_pop;
    end
  end
  // Payload storage is deliberately left uncleared; outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (reset && !flush && w_push)
      r_mem[r_wptr] <= '{imm: u64'(w_imm), tag: IMM_TAG_MAX'(in_tag), fmt_err: w_err};
  end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench for imm_ext_pipe (XLEN=64, plus an XLEN=32 copy for LUI).
module tb_imm_ext_pipe;
  import imm_ext_pipe_pkg::*;
  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [19:0] in_raw = '0;
  im_ext_t in_fmt = EXT_NULL;
  logic [4:0] in_tag = '0;
  logic in_ready, out_valid, out_fmt_err, in_ready32, out_valid32, out_fmt_err32;
  logic [63:0] out_imm;
  logic [31:0] out_imm32;
  logic [4:0] out_tag, out_tag32;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  imm_ext_pipe #(.XLEN(64), .RAW_W(20), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_raw(in_raw), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_fmt_err(out_fmt_err)
  );
  imm_ext_pipe #(.XLEN(32), .RAW_W(20), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_raw(in_raw), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_fmt_err(out_fmt_err32)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [19:0] r, input logic [3:0] f, input logic [4:0] t);
    exp_t e;
    e.imm = '0;
    e.err = 1'b0;
    e.tag = t;
    case (f)
      4'd0: e.imm = '0;
      4'd1, 4'd2: e.imm = {{52{r[11]}}, r[11:0]};
      4'd3: e.imm = {{32{r[19]}}, r, 12'b0};
      4'd4: e.imm = {{43{r[19]}}, r, 1'b0};
      4'd5: e.imm = {{51{r[11]}}, r[11:0], 1'b0};
      4'd6: begin e.imm = {58'b0, r[5:0]}; e.err = r[11:6] != 6'd0; end
`ifdef IMM_EXT_ZIMM_EN
      4'd7: e.imm = {59'b0, r[4:0]};
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!reset) q.delete();
    else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_imm", out_imm, e.imm);
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_err", 64'(out_fmt_err), 64'(e.err));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_raw, in_fmt, in_tag));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [19:0] r, input logic [3:0] f, input logic [4:0] t);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_raw = r; in_fmt = im_ext_t'(f); in_tag = t;
    for (int i = 0; i < 30 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(acc), 1);
  endtask
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() != 0; i++) tick();
    tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", 64'(out_valid), 0);
  endtask
  initial begin
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_imm", out_imm, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 1);
    send(20'h00FFF, 4'd1, 5'd3);
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_tag", 64'(out_tag), 3);
    send(20'h80000, 4'd3, 5'd4);
    chk("lui64", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui32", 64'(out_imm32), 64'h8000_0000);
    send(20'hFFFFF, 4'd4, 5'd5);
    chk("jal", out_imm, 64'hFFFF_FFFF_FFFF_FFFE);
    send(20'h0003F, 4'd6, 5'd6);
    chk("shamt_ok", {out_fmt_err, out_imm[62:0]}, 64'd63);
    send(20'h00040, 4'd6, 5'd7);
    chk("shamt_bad", {out_fmt_err, out_imm[62:0]}, {1'b1, 63'd0});
    send(20'h12345, 4'hF, 5'd8);
    chk("unknown", {out_fmt_err, out_imm[62:0]}, {1'b1, 63'd0});
    send(20'hFFFFF, 4'd7, 5'd9);
`ifdef IMM_EXT_ZIMM_EN
    chk("zimm", {out_fmt_err, out_imm[62:0]}, 64'h1F);
`else
    chk("zimm_off", {out_fmt_err, out_imm[62:0]}, {1'b1, 63'd0});
`endif
    send(20'h00800, 4'd5, 5'd10);
    send(20'h007FF, 4'd2, 5'd11);
    drain();
    out_ready = 1'b0;
    in_valid = 1'b1; in_raw = 20'h1; in_fmt = EXT_ADDI; in_tag = 5'd1;
    tick();
    in_tag = 5'd2; in_raw = 20'h2;
    tick();
    in_tag = 5'd3; in_raw = 20'h3;
    chk("bp_ready_low", 64'(in_ready), 0);
    tick();
    chk("bp_ready_held", 64'(in_ready), 0);
    chk("bp_head_stable", 64'(out_tag), 1);
    out_ready = 1'b1;
    send(20'h3, 4'd1, 5'd3);
    drain();
    out_ready = 1'b0;
    send(20'h4, 4'd1, 5'd4);
    send(20'h5, 4'd1, 5'd5);
    in_valid = 1'b1; in_tag = 5'd9; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_ready", 64'(in_ready), 1);
    chk("flush_imm", out_imm, 0);
    send(20'h6, 4'd1, 5'd6);
    in_valid = 1'b1; in_tag = 5'd12; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", 64'(out_valid), 0);
    drain();
    out_ready = 1'b0;
    send(20'h7, 4'd1, 5'd7);
    send(20'h8, 4'd1, 5'd8);
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_imm", out_imm, 0);
    chk("mid_rst_tag", 64'(out_tag), 0);
    chk("mid_rst_err", 64'(out_fmt_err), 0);
    chk("mid_rst_ready", 64'(in_ready), 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_rel_ready", 64'(in_ready), 1);
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_raw = 20'($urandom);
      in_fmt = im_ext_t'(4'($urandom_range(0, 8)));
      in_tag = 5'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, registered immediate-extension stage for the decode pipeline. Each beat carries a raw 20-bit immediate field and an extension format. The stage produces an XLEN-wide extended immediate, a format-error flag and a pass-through tag. It sits between instruction field split and the execute-stage operand mux. Input and output use valid/ready handshakes, with a 2-entry skid buffer so upstream is never stalled combinationally by out_ready.

Parameters:
XLEN, 64, output immediate width; legal values are 32 and 64 only.
RAW_W, 20, raw immediate field width; minimum 20.
TAG_W, 5, width of the opaque tag carried with each beat (destination register id).

Ports:
clk  input  1  clock, all state updates on its rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
flush  input  1  drop all buffered beats; branch redirect
in_valid  input  1  input beat present
in_ready  output  1  stage can accept a beat this cycle
in_raw  input  RAW_W  raw immediate bits
in_fmt  input  im_ext_t  extension format
in_tag  input  TAG_W  tag, passed through unchanged
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts the beat
out_imm  output  XLEN  extended immediate
out_tag  output  TAG_W  tag of the output beat
out_fmt_err  output  1  unknown format, or illegal shift amount

Behaviour:
- Extension rules (r = in_raw), computed at push and stored in the buffer entry:
  - EXT_NULL: 0.
  - EXT_ADDI and EXT_SD: sign-extend r[11:0].
  - EXT_LUI: sign-extend {r[19:0], 12'b0}. For XLEN=32 no extension is applied.
  - EXT_JAL: sign-extend {r[19:0], 1'b0}.
  - EXT_BEQ: sign-extend {r[11:0], 1'b0}.
  - EXT_SHAMT: zero-extend r[S-1:0], where S = log2(XLEN). out_fmt_err=1 if r[11:S] != 0.
  - Any other encoding: imm=0, out_fmt_err=1.
- Latency: 1 cycle from an accepted input beat to out_valid when the buffer was empty.
- Buffer: 2-entry FIFO; count state EMPTY(0), ONE(1), FULL(2).
  - in_ready = (count != FULL). It is a registered value and never depends on out_ready.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push goes to ONE.
  - ONE: push & !pop goes to FULL; !push & pop goes to EMPTY; push & pop stays ONE, with the new beat becoming the head.
  - FULL: pop goes to ONE; push is impossible.
- out_valid = (count != EMPTY). out_imm, out_tag and out_fmt_err show the head entry and stay stable while out_valid & !out_ready.
- Order is strictly FIFO; no beat is lost or duplicated.
- flush: count goes to EMPTY next cycle. Flush overrides a simultaneous push and pop; the pushed beat is discarded.
- Reset (reset=0 at a clock edge, including mid-transfer): count=EMPTY, out_valid=0, out_imm=0, out_tag=0, out_fmt_err=0.
  - in_ready=0 during the reset cycle and 1 from the first cycle after reset is released.
- Entry payloads are not cleared on flush. Outputs are 0 whenever out_valid=0, for deterministic traces.

Optional Feature:
Macro IMM_EXT_ZIMM_EN.
- Defined: adds format EXT_ZIMM, which zero-extends r[4:0] (CSR immediate) with out_fmt_err=0.
- Undefined: the EXT_ZIMM encoding is treated as unknown (imm=0, out_fmt_err=1).
- The im_ext_t encoding is identical in both builds.

Decomposition:
- The pipes package holds:
  - im_ext_t, extended with EXT_SHAMT and EXT_ZIMM;
  - the constant IMM_RAW_W=20;
  - struct imm_beat_t {imm, tag, fmt_err}.
- The common package supplies u64/u20.
- One sub-module: imm_ext_core, purely combinational, computing {imm, fmt_err} from (raw, fmt) for parameter XLEN.
- imm_ext_pipe holds only the FIFO, handshake and flush logic.

Test Plan:
- XLEN=64, EXT_ADDI, raw=20'h00FFF, tag=3, out_ready=1 -> one cycle later out_valid=1, out_imm=64'hFFFF_FFFF_FFFF_FFFF, out_tag=3, out_fmt_err=0.
- EXT_LUI raw=20'h80000: XLEN=64 -> 64'hFFFF_FFFF_8000_0000; XLEN=32 -> 32'h8000_0000. EXT_JAL raw=20'hFFFFF -> 64'hFFFF_FFFF_FFFF_FFFE.
- EXT_SHAMT: raw=20'h0003F at XLEN=64 -> imm=63, err=0; raw=20'h00040 -> imm=0, err=1; undefined encoding -> imm=0, err=1.
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back -> in_ready drops to 0 after 2 accepts; tag 3 is held upstream. Then out_ready=1 -> tags leave in order 1,2,3, no loss or duplication.
- FULL buffer, assert flush together with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1, and the flushed input beat never appears.
- reset=0 while FULL with out_ready=0 -> next cycle all outputs 0. With IMM_EXT_ZIMM_EN defined, EXT_ZIMM raw=20'hFFFFF -> 64'h1F, err=0; without it -> 0, err=1.
